board_vga_renderer: RTL and testbench
=====================================

// Module: board_vga_renderer
// PURPOSE
//  Downstream of the game-of-life main machine. Consumes its 256-bit board (16x16) and 16-bit generation count.
//  Produces 640x480@60 VGA timing and 12-bit RGB pixels that draw the grid as a square of cells.
//  Board and count are snapshotted once per frame, so a generation update never tears the displayed image.
// PARAMETERS
//  CLK_DIV   4       clk cycles per pixel (100 MHz clk -> 25 MHz pixel)
//  H_ACTIVE  640     visible pixels/line; H_FP 16, H_SYNC 96, H_BP 48 (H_TOTAL 800)
//  V_ACTIVE  480     visible lines/frame; V_FP 10, V_SYNC 2, V_BP 33 (V_TOTAL 525)
//  CELL_PX   24      pixel edge length of one cell (grid = 16*CELL_PX = 384)
//  X_OFS     128     x of grid left edge;  Y_OFS 48  y of grid top edge
//  LIVE_RGB  12'h0F0 live cell colour; DEAD_RGB 12'h000; LINE_RGB 12'h333 grid-line colour
// PORTS
//  clk          in   1    system clock
//  reset_n      in   1    asynchronous, active-low reset
//  board_i      in   256  board; bit row*16+col, bit0 = top-left cell, 1 = live
//  gen_cnt_i    in   16   generation count from main machine
//  hsync_o      out  1    horizontal sync, active low
//  vsync_o      out  1    vertical sync, active low
//  rgb_o        out  12   {R[3:0],G[3:0],B[3:0]}, forced 0 outside active area
//  frame_start_o out 1    one-clk pulse when a new snapshot is taken
//  gen_shown_o  out  16   generation count belonging to the frame being drawn
// BEHAVIOUR
//  - Reset (async, reset_n=0): div, h_cnt, v_cnt = 0; hsync_o = vsync_o = 1; rgb_o = 0;
//    frame_start_o = 0; gen_shown_o = 0; board snapshot = all dead.
//  - pix_tick: asserted one clk in every CLK_DIV, first at div==CLK_DIV-1 after reset release.
//  - On pix_tick: h_cnt 0..799 wraps to 0; v_cnt increments on h_cnt wrap, 0..524 then wraps to 0.
//  - Sync: hsync low when h_cnt in [656,752). vsync low when v_cnt in [490,492).
//  - Snapshot: on pix_tick with h_cnt==799 && v_cnt==524:
//    - board snapshot <= board_i; gen_shown_o <= gen_cnt_i; frame_start_o = 1 for that clk only.
//    - Inputs changing at any other time have no visible effect until the next snapshot.
//  - Cell addressing: incremental sub-pixel and cell counters only, no divider.
//    - Column counters reset at h_cnt==X_OFS; row counters reset at v_cnt==Y_OFS.
//    - sub counts 0..CELL_PX-1, then cell index increments.
//  - Pixel colour (active area h<640, v<480):
//    - Outside grid: 0.
//    - Inside grid with sub_x==0 or sub_y==0: LINE_RGB.
//    - Otherwise: LIVE_RGB if snapshot[row*16+col] else DEAD_RGB.
//  - Latency: rgb_o, hsync_o, vsync_o are all registered on pix_tick and change together.
//    They lag h_cnt/v_cnt by exactly one pixel, so colour and sync stay aligned.
//  - Blanking (h>=640 or v>=480): rgb_o = 0, no exceptions.
//  - Simultaneous events: snapshot tick and board_i change in the same clk -> the new value is captured.
//  - Reset mid-frame: outputs return to reset values immediately.
//    After release, timing restarts at h=0, v=0 and the board shows dead until the first snapshot.
// TESTING
//  1 Reset released, run 2 frames -> hsync period 3200 clk, low 384 clk; vsync period 1,680,000 clk, low 6400 clk.
//  2 board_i=all 1s before frame-1 snapshot -> in frame 2:
//    pixel (129,49)=12'h0F0; pixel (128,60)=12'h333; pixel (100,100)=0; pixel (700,10)=0.
//  3 board_i bit17 only (row1,col1) -> pixel (160,80)=12'h0F0; pixel (140,60)=12'h000; pixel (184,80)=12'h000.
//  4 Toggle board_i and gen_cnt_i=16'd42 at mid-frame (v=200):
//    - rgb unchanged for the rest of the frame; frame_start_o pulses once at frame end.
//    - gen_shown_o becomes 42 only after that pulse.
//  5 Assert reset_n=0 at v=300, hold 10 clk, release -> hsync_o=vsync_o=1, rgb_o=0 while held.
//    First hsync falling edge occurs 656*4 clk (+/- 4 clk) after release.
//  6 board_i changes exactly on the snapshot clk -> the new board is displayed in the following frame.

Source files
------------

// File: rtl/board_vga_renderer.sv
`timescale 1ns/1ps
// board_vga_renderer: VGA scan-out of a 16x16 life board as a grid of square cells.
// Board and generation count are latched once per frame so an update never tears the picture.
module board_vga_renderer #(
  parameter int          CLK_DIV  = 4,
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          CELL_PX  = 24,
  parameter int          X_OFS    = 128,
  parameter int          Y_OFS    = 48,
  parameter logic [11:0] LIVE_RGB = 12'h0F0,
  parameter logic [11:0] DEAD_RGB = 12'h000,
  parameter logic [11:0] LINE_RGB = 12'h333
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [255:0] board_i,
  input  logic [15:0]  gen_cnt_i,
  output logic         hsync_o,
  output logic         vsync_o,
  output logic [11:0]  rgb_o,
  output logic         frame_start_o,
  output logic [15:0]  gen_shown_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SUB_W   = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int GRID_PX = 16 * CELL_PX;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ACT    = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0]   V_ACT    = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0]   HS_BEG   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0]   VS_BEG   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [H_W-1:0]   X_BEG    = H_W'(X_OFS);
  localparam logic [H_W-1:0]   X_END    = H_W'(X_OFS + GRID_PX);
  localparam logic [V_W-1:0]   Y_BEG    = V_W'(Y_OFS);
  localparam logic [V_W-1:0]   Y_END    = V_W'(Y_OFS + GRID_PX);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);

  logic [DIV_W-1:0] div_r;
  logic [H_W-1:0]   h_cnt_r;
  logic [V_W-1:0]   v_cnt_r;
  logic [H_W-1:0]   h_nxt_s;
  logic [V_W-1:0]   v_nxt_s;
  logic [SUB_W-1:0] sub_x_r;
  logic [SUB_W-1:0] sub_y_r;
  logic [3:0]       cell_x_r;
  logic [3:0]       cell_y_r;
  logic [255:0]     snap_r;
  logic             pix_tick_s;
  logic             frame_end_s;
  logic             active_s;
  logic             in_grid_s;
  logic [11:0]      pix_rgb_s;
  logic             hsync_nxt_s;
  logic             vsync_nxt_s;

  assign pix_tick_s  = (div_r == DIV_LAST);
  assign frame_end_s = (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);

  // Pixel-rate divider
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        div_r <= {DIV_W{1'b0}};
    else if (pix_tick_s) div_r <= {DIV_W{1'b0}};
    else                 div_r <= div_r + DIV_W'(1);
  end

  // Next raster position
  always_comb begin
    h_nxt_s = h_cnt_r + H_W'(1);
    v_nxt_s = v_cnt_r;
    if (h_cnt_r == H_LAST) begin
      h_nxt_s = {H_W{1'b0}};
      if (v_cnt_r == V_LAST) v_nxt_s = {V_W{1'b0}};
      else                   v_nxt_s = v_cnt_r + V_W'(1);
    end else begin
      v_nxt_s = v_cnt_r;
    end
  end

  // Raster counters plus incremental cell addressing (no divider needed)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_r  <= {H_W{1'b0}};
      v_cnt_r  <= {V_W{1'b0}};
      sub_x_r  <= {SUB_W{1'b0}};
      sub_y_r  <= {SUB_W{1'b0}};
      cell_x_r <= 4'd0;
      cell_y_r <= 4'd0;
    end else if (pix_tick_s) begin
      h_cnt_r <= h_nxt_s;
      v_cnt_r <= v_nxt_s;
      if (h_nxt_s == X_BEG) begin
        sub_x_r  <= {SUB_W{1'b0}};
        cell_x_r <= 4'd0;
      end else if (sub_x_r == SUB_LAST) begin
        sub_x_r  <= {SUB_W{1'b0}};
        cell_x_r <= cell_x_r + 4'd1;
      end else begin
        sub_x_r  <= sub_x_r + SUB_W'(1);
      end
      // Row counters advance only at line wrap
      if (h_cnt_r == H_LAST) begin
        if (v_nxt_s == Y_BEG) begin
          sub_y_r  <= {SUB_W{1'b0}};
          cell_y_r <= 4'd0;
        end else if (sub_y_r == SUB_LAST) begin
          sub_y_r  <= {SUB_W{1'b0}};
          cell_y_r <= cell_y_r + 4'd1;
        end else begin
          sub_y_r  <= sub_y_r + SUB_W'(1);
        end
      end
    end
  end

  // Colour and sync for the pixel currently addressed by h_cnt/v_cnt
  always_comb begin
    pix_rgb_s   = 12'h000;
    active_s    = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    in_grid_s   = (h_cnt_r >= X_BEG) && (h_cnt_r < X_END) &&
                  (v_cnt_r >= Y_BEG) && (v_cnt_r < Y_END);
    hsync_nxt_s = !((h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END));
    vsync_nxt_s = !((v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END));
    if (!active_s || !in_grid_s)                          pix_rgb_s = 12'h000;
    else if (sub_x_r == {SUB_W{1'b0}} || sub_y_r == {SUB_W{1'b0}}) pix_rgb_s = LINE_RGB;
    else if (snap_r[{cell_y_r, cell_x_r}])                 pix_rgb_s = LIVE_RGB;
    else                                                   pix_rgb_s = DEAD_RGB;
  end

  // Registered outputs and once-per-frame snapshot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_o       <= 1'b1;
      vsync_o       <= 1'b1;
      rgb_o         <= 12'h000;
      frame_start_o <= 1'b0;
      gen_shown_o   <= 16'd0;
      snap_r        <= {256{1'b0}};
    end else begin
      frame_start_o <= pix_tick_s && frame_end_s;
      if (pix_tick_s) begin
        hsync_o <= hsync_nxt_s;
        vsync_o <= vsync_nxt_s;
        rgb_o   <= pix_rgb_s;
      end
      if (pix_tick_s && frame_end_s) begin
        snap_r      <= board_i;
        gen_shown_o <= gen_cnt_i;
      end
    end
  end

endmodule

// File: tb/tb_board_vga_renderer.sv
`timescale 1ns/1ps
// Directed bench: a scaled-down raster instance for frame-level behaviour and a
// full 640x480 instance for horizontal timing at the real pixel rate.
module tb_board_vga_renderer;

  // Scaled geometry: 80x60 total, 64x52 active, 3-px cells, grid at (8,2), 2 clk/pixel
  localparam int HT        = 80;
  localparam int FRAME_CLK = 2 * 80 * 60;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [255:0] board_i = {256{1'b1}};
  logic [15:0]  gen_cnt_i = 16'd7;
  logic         hsync, vsync, frame_start;
  logic [11:0]  rgb;
  logic [15:0]  gen_shown;
  logic         f_hsync, f_vsync, f_frame_start;
  logic [11:0]  f_rgb;
  logic [15:0]  f_gen_shown;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int fs_cnt = 0;
  int t0, t1, t2;

  always #5 clk = ~clk;

  board_vga_renderer #(
    .CLK_DIV(2), .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(52), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .CELL_PX(3), .X_OFS(8), .Y_OFS(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .board_i(board_i), .gen_cnt_i(gen_cnt_i),
    .hsync_o(hsync), .vsync_o(vsync), .rgb_o(rgb),
    .frame_start_o(frame_start), .gen_shown_o(gen_shown)
  );

  board_vga_renderer dut_full (
    .clk(clk), .reset_n(reset_n), .board_i(board_i), .gen_cnt_i(gen_cnt_i),
    .hsync_o(f_hsync), .vsync_o(f_vsync), .rgb_o(f_rgb),
    .frame_start_o(f_frame_start), .gen_shown_o(f_gen_shown)
  );

  // Clock edges since the last reset release
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Count frame_start pulses of the scaled instance
  always @(posedge clk) begin
    if (frame_start) fs_cnt <= fs_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
    check("cyc_align", cyc, target);
  endtask

  task automatic wait_lvl(input string tag, input int sel, input logic lvl, input int limit,
                          output int t);
    int   n;
    logic s;
    n = 0;
    forever begin
      case (sel)
        0:       s = hsync;
        1:       s = vsync;
        default: s = f_hsync;
      endcase
      if (s === lvl || n >= limit) break;
      @(negedge clk);
      n++;
    end
    check({tag, "_reached"}, {31'd0, s}, {31'd0, lvl});
    t = cyc;
  endtask

  task automatic pix(input string tag, input int f, input int x, input int y,
                     input logic [11:0] exp);
    wait_cyc(f * FRAME_CLK + 2 * (y * HT + x + 1));
    check(tag, {20'd0, rgb}, {20'd0, exp});
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_hsync", {31'd0, hsync}, 32'd1);
    check("rst_vsync", {31'd0, vsync}, 32'd1);
    check("rst_rgb", {20'd0, rgb}, 32'd0);
    check("rst_fs", {31'd0, frame_start}, 32'd0);
    check("rst_gen", {16'd0, gen_shown}, 32'd0);
    check("rst_f_vsync", {31'd0, f_vsync}, 32'd1);
    check("rst_f_rgb", {20'd0, f_rgb}, 32'd0);
    check("rst_f_fs_gen", {15'd0, f_frame_start, f_gen_shown}, 32'd0);
    reset_n = 1'b1;

    // Horizontal timing, scaled instance
    wait_lvl("h_fall1", 0, 1'b0, 1000, t0);
    check("h_first_fall", t0, 32'd138);
    wait_lvl("h_rise", 0, 1'b1, 1000, t1);
    check("h_low_len", t1 - t0, 32'd16);
    wait_lvl("h_fall2", 0, 1'b0, 1000, t2);
    check("h_period", t2 - t0, 32'd160);

    // Frame 0 shows the dead reset snapshot; grid lines still drawn
    pix("f0_line_8_3", 0, 8, 3, 12'h333);
    pix("f0_dead_9_3", 0, 9, 3, 12'h000);

    // Horizontal timing at full 640x480 scale
    wait_lvl("fh_fall1", 2, 1'b0, 10000, t0);
    check("fh_first_fall_win", {31'd0, (t0 >= 2620 && t0 <= 2628)}, 32'd1);
    wait_lvl("fh_rise", 2, 1'b1, 10000, t1);
    check("fh_low_len", t1 - t0, 32'd384);
    wait_lvl("fh_fall2", 2, 1'b0, 10000, t2);
    check("fh_period", t2 - t0, 32'd3200);

    // Vertical sync, scaled instance
    wait_lvl("v_fall1", 1, 1'b0, 20000, t0);
    check("v_first_fall", t0, 32'd8642);
    wait_lvl("v_rise", 1, 1'b1, 20000, t1);
    check("v_low_len", t1 - t0, 32'd320);

    // First snapshot
    wait_cyc(FRAME_CLK - 1);
    check("fs0_before", {31'd0, frame_start}, 32'd0);
    check("gen_before", {16'd0, gen_shown}, 32'd0);
    wait_cyc(FRAME_CLK);
    check("fs0_pulse", {31'd0, frame_start}, 32'd1);
    check("gen_after0", {16'd0, gen_shown}, 32'd7);
    wait_cyc(FRAME_CLK + 1);
    check("fs0_end", {31'd0, frame_start}, 32'd0);

    // Frame 1: all-live board
    pix("f1_live_9_3", 1, 9, 3, 12'h0F0);
    pix("f1_line_8_5", 1, 8, 5, 12'h333);
    pix("f1_right_out", 1, 56, 10, 12'h000);
    pix("f1_hblank", 1, 70, 10, 12'h000);
    pix("f1_left_out", 1, 4, 20, 12'h000);

    // Mid-frame input change must not show until the next snapshot
    wait_cyc(FRAME_CLK + 2 * 26 * HT);
    board_i = {256{1'b0}};
    board_i[17] = 1'b1;
    gen_cnt_i = 16'd42;
    pix("f1_hold_9_30", 1, 9, 30, 12'h0F0);
    check("gen_hold", {16'd0, gen_shown}, 32'd7);
    pix("f1_hold_55_49", 1, 55, 49, 12'h0F0);
    pix("f1_below_grid", 1, 20, 50, 12'h000);
    wait_lvl("v_fall2", 1, 1'b0, 20000, t1);
    check("v_period", t1 - t0, 32'd9600);
    pix("f1_vblank", 1, 10, 54, 12'h000);

    wait_cyc(2 * FRAME_CLK - 1);
    check("fs1_before", {31'd0, frame_start}, 32'd0);
    check("fs_count_f1", fs_cnt, 32'd1);
    check("gen_still7", {16'd0, gen_shown}, 32'd7);
    wait_cyc(2 * FRAME_CLK);
    check("fs1_pulse", {31'd0, frame_start}, 32'd1);
    check("gen_42", {16'd0, gen_shown}, 32'd42);
    wait_cyc(2 * FRAME_CLK + 1);
    check("fs_count_f2", fs_cnt, 32'd2);

    // Frame 2: single live cell at row1,col1
    pix("f2_dead_10_4", 2, 10, 4, 12'h000);
    pix("f2_line_11_6", 2, 11, 6, 12'h333);
    pix("f2_live_12_6", 2, 12, 6, 12'h0F0);
    pix("f2_dead_15_6", 2, 15, 6, 12'h000);

    // Input change in the snapshot clock is captured
    wait_cyc(3 * FRAME_CLK - 1);
    board_i = 256'd1;
    gen_cnt_i = 16'd43;
    wait_cyc(3 * FRAME_CLK);
    check("fs2_pulse", {31'd0, frame_start}, 32'd1);
    check("gen_43", {16'd0, gen_shown}, 32'd43);
    pix("f3_live_9_3", 3, 9, 3, 12'h0F0);
    pix("f3_dead_12_6", 3, 12, 6, 12'h000);

    // Reset mid-frame
    pix("f3_line_20_29", 3, 20, 29, 12'h333);
    reset_n = 1'b0;
    #1;
    check("mrst_rgb", {20'd0, rgb}, 32'd0);
    check("mrst_gen", {16'd0, gen_shown}, 32'd0);
    check("mrst_hv", {30'd0, hsync, vsync}, 32'd3);
    repeat (10) @(negedge clk);
    check("mrst_hold_rgb", {20'd0, rgb}, 32'd0);
    check("mrst_hold_hv", {29'd0, hsync, vsync, f_hsync}, 32'd7);
    reset_n = 1'b1;

    wait_lvl("rh_fall", 0, 1'b0, 1000, t0);
    check("rst_h_first_fall", t0, 32'd138);
    pix("r_line_8_3", 0, 8, 3, 12'h333);
    pix("r_dead_9_3", 0, 9, 3, 12'h000);
    wait_lvl("rfh_fall", 2, 1'b0, 10000, t0);
    check("rst_fh_first_fall_win", {31'd0, (t0 >= 2620 && t0 <= 2628)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
